// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of a 16-bit pipeline. It holds the PC, reads
//   instruction memory combinationally, and fills the IF/ID pipeline register.
//   It also handles load-use stalls, ID-stage redirects and the HLT opcode.
//
// Ports
//   clk           in   1   rising-edge clock
//   rst_n         in   1   asynchronous active-low reset
//   stall         in   1   hazard-unit stall; holds PC and IF/ID
//   branch_taken  in   1   redirect request from ID
//   branch_target in  16   redirect byte address (bit 0 ignored)
//   imem_addr     out 16   instruction memory address (the PC register)
//   imem_data     in  16   instruction at imem_addr, same-cycle read
//   ID_Instr      out 16   registered instruction for decode
//   ID_PCplus2    out 16   registered PC+2 of ID_Instr
//   ID_Valid      out  1   1 = real instruction, 0 = bubble
//   halted        out  1   high while the stage is in HALTED
// -----------------------------------------------------------------------------
module fetch_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    output logic [15:0] ID_Instr,
    output logic [15:0] ID_PCplus2,
    output logic        ID_Valid,
    output logic        halted
);

    typedef enum logic [0:0] {
        ST_FETCH  = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [3:0] OP_HLT = 4'hF;

    state_t      state_r;
    logic [15:0] pc_r;
    logic [15:0] id_instr_r;
    logic [15:0] id_pcplus2_r;
    logic        id_valid_r;
    logic        halted_r;

    logic [15:0] pc_plus2_s;
    logic        is_hlt_s;

    // PC increment wraps naturally at 16 bits; HLT decode on the fetched opcode.
    always_comb begin
        pc_plus2_s = pc_r + 16'd2;
        is_hlt_s   = (imem_data[15:12] == OP_HLT);
    end

    // Fetch FSM: PC, IF/ID register and halted flag, all updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_FETCH;
            pc_r         <= 16'h0000;
            id_instr_r   <= 16'h0000;
            id_pcplus2_r <= 16'h0000;
            id_valid_r   <= 1'b0;
            halted_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (stall) begin
                        // Hold everything; redirect and HLT wait for release.
                        state_r <= ST_FETCH;
                    end else if (branch_taken) begin
                        // Redirect squashes this cycle's fetch, even a HLT.
                        pc_r         <= {branch_target[15:1], 1'b0};
                        id_instr_r   <= 16'h0000;
                        id_pcplus2_r <= 16'h0000;
                        id_valid_r   <= 1'b0;
                    end else if (is_hlt_s) begin
                        // HLT reaches decode; PC stays on the HLT address.
                        id_instr_r   <= imem_data;
                        id_pcplus2_r <= pc_plus2_s;
                        id_valid_r   <= 1'b1;
                        halted_r     <= 1'b1;
                        state_r      <= ST_HALTED;
                    end else begin
                        id_instr_r   <= imem_data;
                        id_pcplus2_r <= pc_plus2_s;
                        id_valid_r   <= 1'b1;
                        pc_r         <= pc_plus2_s;
                    end
                end
                ST_HALTED: begin
                    // PC frozen, redirects ignored; only reset leaves this state.
                    if (stall) begin
                        state_r <= ST_HALTED;
                    end else begin
                        id_instr_r   <= 16'h0000;
                        id_pcplus2_r <= 16'h0000;
                        id_valid_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r      <= ST_FETCH;
                    pc_r         <= 16'h0000;
                    id_instr_r   <= 16'h0000;
                    id_pcplus2_r <= 16'h0000;
                    id_valid_r   <= 1'b0;
                    halted_r     <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = pc_r;
    assign ID_Instr   = id_instr_r;
    assign ID_PCplus2 = id_pcplus2_r;
    assign ID_Valid   = id_valid_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. A small instruction-memory model answers
//   imem_addr combinationally. Each step advances one clock; outputs are
//   sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] imem_addr;
    logic [15:0] imem_data;
    logic [15:0] ID_Instr;
    logic [15:0] ID_PCplus2;
    logic        ID_Valid;
    logic        halted;

    int n_vec  = 0;
    int n_miss = 0;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .ID_Instr      (ID_Instr),
        .ID_PCplus2    (ID_PCplus2),
        .ID_Valid      (ID_Valid),
        .halted        (halted)
    );

    // Instruction memory contents; unlisted words are opcode-3 instructions.
    function automatic logic [15:0] mem_model(input logic [15:0] a);
        logic [15:0] w;
        case (a)
            16'h0000: w = 16'h1123;
            16'h0002: w = 16'h2234;
            16'h0010: w = 16'hF000;
            default:  w = {4'h3, a[11:0]};
        endcase
        return w;
    endfunction

    assign imem_data = mem_model(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the full visible state in one call.
    task automatic chk_all(input string tag, input logic [15:0] a, input logic [15:0] ins,
                           input logic [15:0] p2, input logic v, input logic h);
        chk({tag, ".addr"},   imem_addr,  a);
        chk({tag, ".instr"},  ID_Instr,   ins);
        chk({tag, ".pc2"},    ID_PCplus2, p2);
        chk({tag, ".valid"},  {15'd0, ID_Valid}, {15'd0, v});
        chk({tag, ".halted"}, {15'd0, halted},   {15'd0, h});
    endtask

    initial begin
        rst_n         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 16'h0000;
        #1 rst_n = 1'b0;
        step();
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #2 rst_n = 1'b1;

        // Sequential fetch
        step(); chk_all("seq1", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0);
        step(); chk_all("seq2", 16'h0004, 16'h2234, 16'h0004, 1'b1, 1'b0);

        // Stall for two cycles at PC=0x0004
        stall = 1'b1;
        step(); chk_all("stall1", 16'h0004, 16'h2234, 16'h0004, 1'b1, 1'b0);
        step(); chk_all("stall2", 16'h0004, 16'h2234, 16'h0004, 1'b1, 1'b0);
        stall = 1'b0;
        step(); chk_all("unstall", 16'h0006, 16'h3004, 16'h0006, 1'b1, 1'b0);

        // Redirect blocked by stall, then taken
        stall = 1'b1; branch_taken = 1'b1; branch_target = 16'h0041;
        step(); chk_all("br_stalled", 16'h0006, 16'h3004, 16'h0006, 1'b1, 1'b0);
        stall = 1'b0;
        step(); chk_all("br_taken", 16'h0040, 16'h0000, 16'h0000, 1'b0, 1'b0);
        branch_taken = 1'b0;
        step(); chk_all("br_after", 16'h0042, 16'h3040, 16'h0042, 1'b1, 1'b0);

        // PC wrap at 0xFFFE
        branch_taken = 1'b1; branch_target = 16'hFFFF;
        step(); chk("wrap_pre.addr", imem_addr, 16'hFFFE);
        branch_taken = 1'b0;
        step(); chk_all("wrap", 16'h0000, 16'h3FFE, 16'h0000, 1'b1, 1'b0);

        // Redirect beats HLT
        branch_taken = 1'b1; branch_target = 16'h0010;
        step(); chk("to_hlt.addr", imem_addr, 16'h0010);
        branch_target = 16'h0100;
        step(); chk_all("br_vs_hlt", 16'h0100, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Halt
        branch_target = 16'h0010;
        step(); chk("to_hlt2.addr", imem_addr, 16'h0010);
        branch_taken = 1'b0;
        step(); chk_all("hlt", 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1);
        stall = 1'b1;
        step(); chk_all("hlt_stall", 16'h0010, 16'hF000, 16'h0012, 1'b1, 1'b1);
        stall = 1'b0;
        step(); chk_all("hlt_bubble", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1);
        branch_taken = 1'b1; branch_target = 16'h0200;
        step(); chk_all("hlt_br_ign", 16'h0010, 16'h0000, 16'h0000, 1'b0, 1'b1);
        branch_taken = 1'b0;

        // Async reset between edges while halted
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        #3 rst_n = 1'b1;
        step(); chk_all("post_rst", 16'h0002, 16'h1123, 16'h0002, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have port stall, input, 1, the hazard-unit load-use stall that holds the PC and the IF/ID register.
REQ-004 SHALL have port branch_taken, input, 1, the ID-stage redirect request.
REQ-005 SHALL have port branch_target, input, 16, the redirect byte address.
REQ-006 SHALL have port imem_addr, output, 16, the instruction memory read address, equal to the PC register.
REQ-007 SHALL have port imem_data, input, 16, the instruction at imem_addr, valid in the same cycle (combinational read).
REQ-008 SHALL have port ID_Instr, output, 16, the registered instruction presented to decode.
REQ-009 SHALL have port ID_PCplus2, output, 16, the registered PC+2 of ID_Instr.
REQ-010 SHALL have port ID_Valid, output, 1, high when ID_Instr is a real fetched instruction and low for a bubble.
REQ-011 SHALL have port halted, output, 1, high while the FSM is in HALTED.

Function
REQ-012 SHALL hold the PC as 16 bits with bit 0 always 0; branch_target[0] is ignored.
REQ-013 SHALL compute PC+2 modulo 2^16, so 0xFFFE wraps to 0x0000.
REQ-014 SHALL implement FSM states FETCH and HALTED; reset state is FETCH.
REQ-015 SHALL apply per-edge priority in FETCH as: stall, then branch_taken, then HLT detect, then normal.
REQ-016 In FETCH with stall=1, SHALL leave PC, ID_Instr, ID_PCplus2, ID_Valid and the state unchanged; branch_taken and HLT are ignored that cycle.
REQ-017 In FETCH with stall=0 and branch_taken=1, SHALL load PC <= {branch_target[15:1],0} and load a bubble into IF/ID (ID_Instr=0x0000, ID_PCplus2=0x0000, ID_Valid=0).
REQ-018 A branch flush SHALL squash the instruction fetched that cycle, including a HLT, and SHALL NOT enter HALTED.
REQ-019 In FETCH with stall=0, branch_taken=0 and imem_data[15:12]=4'hF (HLT), SHALL capture the HLT into IF/ID with ID_Valid=1 and ID_PCplus2=PC+2, keep the PC unchanged, and enter HALTED.
REQ-020 In FETCH with stall=0, branch_taken=0 and any other opcode, SHALL load ID_Instr=imem_data, ID_PCplus2=PC+2 and ID_Valid=1, and set PC <= PC+2.
REQ-021 In HALTED, the PC SHALL stay frozen.
REQ-022 In HALTED, when stall=0 the IF/ID register SHALL load a bubble every cycle; when stall=1 it SHALL hold.
REQ-023 In HALTED, branch_taken SHALL be ignored; the only exit from HALTED is reset.
REQ-024 SHALL drive halted high from the same edge that captures the HLT into IF/ID.
REQ-025 Fetch-to-decode latency SHALL be 1 cycle: an instruction at imem_addr in cycle N appears on ID_Instr in cycle N+1 when not stalled.

Reset
REQ-026 While rst_n=0, SHALL force immediately, without waiting for clk: PC=0x0000, imem_addr=0x0000, ID_Instr=0x0000, ID_PCplus2=0x0000, ID_Valid=0, halted=0, state=FETCH.
REQ-027 Reset asserted mid-stall, mid-redirect or in HALTED SHALL discard all in-flight state; after rst_n rises, the first edge fetches from 0x0000.

Verification
REQ-028 Sequential fetch: reset, memory holds 0x1123 at 0x0000 and 0x2234 at 0x0002, no stall -> cycle 1: ID_Instr=0x1123, ID_PCplus2=0x0002, ID_Valid=1; cycle 2: ID_Instr=0x2234, imem_addr=0x0004.
REQ-029 Stall: PC=0x0004, stall=1 for 2 cycles -> imem_addr stays 0x0004 and ID_* unchanged for both cycles; on release, ID_PCplus2=0x0006.
REQ-030 Redirect: branch_taken=1, branch_target=0x0041, stall=0 -> next cycle imem_addr=0x0040, ID_Valid=0, ID_Instr=0x0000; with stall=1 also asserted, no redirect occurs.
REQ-031 Halt: HLT 0xF000 at 0x0010 -> ID_Instr=0xF000, ID_Valid=1, halted=1, imem_addr stays 0x0010; later cycles give ID_Valid=0, and branch_taken has no effect.
REQ-032 Redirect beats HLT: imem_data=0xF000 with branch_taken=1, target 0x0100 -> halted=0, imem_addr=0x0100, ID_Valid=0.
REQ-033 Wrap and async reset: PC=0xFFFE, no stall -> imem_addr=0x0000 next; rst_n driven low between clock edges -> all outputs 0 immediately.
